// File: rtl/cdpwm_pkg.sv
// cdpwm_pkg: shared types and helpers for the countdown-PWM capture path.
package cdpwm_pkg;

    typedef enum logic [1:0] {CAP_IDLE, CAP_HIGH, CAP_LOW} cap_state_t;

    // Returns {rise, fall} from the current and previous sample of a level.
    function automatic logic [1:0] edge_det(input logic s, input logic s_last);
        return {s & ~s_last, ~s & s_last};
    endfunction

endpackage

// File: rtl/cdpwm_capture_sync_edge_det.sv
// sync_edge_det: multi-flop synchronizer followed by a registered-last rise/fall detector.
module sync_edge_det
    import cdpwm_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic sysclk,
    input  logic sysreset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              s_last;

    always_ff @(posedge sysclk) begin
        if (!sysreset) begin
            sync   <= '0;
            s_last <= 1'b0;
        end else begin
            sync   <= {sync[STAGES-2:0], din};
            s_last <= sync[STAGES-1];
        end
    end

    assign {rise, fall} = edge_det(sync[STAGES-1], s_last);

endmodule

// File: rtl/cdpwm_capture.sv
// cdpwm_capture: measures period and high time of an async PWM input in timebase ticks,
// with a valid/ack result handshake and sticky overrun/timeout flags.
module cdpwm_capture
    import cdpwm_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             sysclk,
    input  logic             sysreset,
    input  logic             counter_event,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             capture_valid,
    input  logic             capture_ack,
    output logic             overrun,
    output logic             timeout,
    input  logic             flags_clear
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    cap_state_t       state, state_nxt;
    logic             rise, fall, event_last, tick;
    logic [WIDTH-1:0] hi_cnt, per_cnt, per_tot;
    logic             per_sat, active, do_cap, do_to, cnt_clr, hi_inc, per_inc;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync (
        .sysclk   (sysclk),
        .sysreset (sysreset),
        .din      (pwm_in),
        .rise     (rise),
        .fall     (fall)
    );

    assign tick    = counter_event & ~event_last;
    assign per_sat = per_cnt == CNT_MAX;
    // A tick landing on the closing edge still belongs to the finished period.
    assign per_tot = per_cnt + WIDTH'(tick);

    always_ff @(posedge sysclk) begin
        if (!sysreset) begin
            state      <= CAP_IDLE;
            event_last <= 1'b0;
        end else begin
            state      <= state_nxt;
            event_last <= counter_event;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CAP_IDLE: state_nxt = rise ? CAP_HIGH : CAP_IDLE;
            CAP_HIGH: state_nxt = per_sat ? CAP_IDLE : fall ? CAP_LOW : CAP_HIGH;
            CAP_LOW:  state_nxt = per_sat ? CAP_IDLE : rise ? CAP_HIGH : CAP_LOW;
            default:  state_nxt = CAP_IDLE;
        endcase
    end

    always_comb begin
        active  = state != CAP_IDLE;
        do_to   = active && per_sat;
        do_cap  = state == CAP_LOW && rise && !per_sat;
        cnt_clr = !active || per_sat || do_cap;
        hi_inc  = state == CAP_HIGH && tick;
        per_inc = active && tick;
    end

    // Clearing on saturation keeps both counters from ever wrapping.
    always_ff @(posedge sysclk) begin
        if (!sysreset || cnt_clr) begin
            hi_cnt  <= '0;
            per_cnt <= '0;
        end else begin
            hi_cnt  <= hi_cnt + WIDTH'(hi_inc);
            per_cnt <= per_cnt + WIDTH'(per_inc);
        end
    end

    always_ff @(posedge sysclk) begin
        if (!sysreset) begin
            period        <= '0;
            high_time     <= '0;
            capture_valid <= 1'b0;
            overrun       <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            if (do_cap) begin
                period    <= per_tot;
                high_time <= hi_cnt;
            end
            capture_valid <= do_cap | (capture_valid & ~capture_ack);
            overrun       <= (do_cap & capture_valid & ~capture_ack) | (overrun & ~flags_clear);
            timeout       <= do_to | (timeout & ~flags_clear);
        end
    end

endmodule

// File: tb/tb_cdpwm_capture.sv
// tb_cdpwm_capture: directed vector table plus hand sequences for reset, latency and edge/tick coincidence.
module tb_cdpwm_capture;

    logic       sysclk = 1'b0;
    logic       sysreset, counter_event, pwm_in, capture_ack, flags_clear;
    logic [7:0] period, high_time;
    logic       capture_valid, overrun, timeout;
    int         n_vec = 0;
    int         n_bad = 0;

    typedef struct {
        int         hi;
        int         lo;
        int         ack_at;
        int         fc_at;
        logic [7:0] ep;
        logic [7:0] eh;
        logic       ev;
        logic       eo;
        logic       et;
    } vec_t;

    vec_t vecs[19];

    cdpwm_capture #(.WIDTH(8), .SYNC_STAGES(3)) dut (
        .sysclk        (sysclk),
        .sysreset      (sysreset),
        .counter_event (counter_event),
        .pwm_in        (pwm_in),
        .period        (period),
        .high_time     (high_time),
        .capture_valid (capture_valid),
        .capture_ack   (capture_ack),
        .overrun       (overrun),
        .timeout       (timeout),
        .flags_clear   (flags_clear)
    );

    always #5 sysclk = ~sysclk;

    task automatic cyc(input logic ev, input logic p, input logic ack, input logic fc);
        counter_event = ev;
        pwm_in        = p;
        capture_ack   = ack;
        flags_clear   = fc;
        @(posedge sysclk);
        #1;
    endtask

    // One timebase tick period: tick on the first clock, pwm level a with it, b after.
    task automatic slot(input logic a, input logic b);
        cyc(1'b1, a, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, b, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input logic [7:0] ep, input logic [7:0] eh,
                       input logic ev, input logic eo, input logic et);
        n_vec++;
        if (period !== ep || high_time !== eh || capture_valid !== ev || overrun !== eo || timeout !== et) begin
            n_bad++;
            $display("FAIL %s: got per=%0d hi=%0d valid=%b ovr=%b to=%b, expected per=%0d hi=%0d valid=%b ovr=%b to=%b",
                     name, period, high_time, capture_valid, overrun, timeout, ep, eh, ev, eo, et);
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int idx = 0;
        for (int s = 0; s < v.hi + v.lo; s++) begin
            for (int o = 0; o < 4; o++) begin
                cyc(o == 0, s < v.hi, idx == v.ack_at, idx == v.fc_at);
                idx++;
            end
        end
        chk(name, v.ep, v.eh, v.ev, v.eo, v.et);
    endtask

    initial begin
        // Each row drives one pwm cycle; its rising edge captures the previous row's cycle.
        vecs[0]  = '{12,  20, -1, -1,  8'd0,  8'd0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{12,  20, -1, -1, 8'd32, 8'd12, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{12,  20, -1, -1, 8'd32, 8'd12, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{12,  20, -1, 10, 8'd32, 8'd12, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{12,  20, -1,  3, 8'd32, 8'd12, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{12,  20, -1, 10, 8'd32, 8'd12, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{12,  20,  3, -1, 8'd32, 8'd12, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{12,  20, 20, 21, 8'd32, 8'd12, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{12,  20, -1, -1, 8'd32, 8'd12, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{ 5,   3, -1, -1, 8'd32, 8'd12, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{ 7,   9,  3,  3,  8'd8,  8'd5, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{ 1,   1, -1, -1, 8'd16,  8'd7, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{12,  20,  3,  5,  8'd2,  8'd1, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{300,  5,  3, -1, 8'd32, 8'd12, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{10,  10, -1, 20, 8'd32, 8'd12, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{10,  10,  3, -1, 8'd20, 8'd10, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{ 0, 300, -1, -1, 8'd20, 8'd10, 1'b1, 1'b0, 1'b1};
        vecs[17] = '{ 3,   4, -1,  1, 8'd20, 8'd10, 1'b1, 1'b0, 1'b0};
        vecs[18] = '{ 3,   4,  3, -1,  8'd7,  8'd3, 1'b1, 1'b0, 1'b0};

        sysreset = 1'b0;
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        sysreset = 1'b1;
        chk("reset", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 19; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset while HIGH: pwm drops one clock earlier so the synchronizer sees no edge afterwards.
        repeat (2) slot(1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        sysreset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        sysreset = 1'b1;
        chk("midreset", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) slot(1'b0, 1'b0);
        run_vec('{6, 4, -1, -1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0}, "post_reset_first");
        run_vec('{6, 4, -1, -1, 8'd10, 8'd6, 1'b1, 1'b0, 1'b0}, "post_reset_second");

        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("ack_clear", 8'd10, 8'd6, 1'b0, 1'b0, 1'b0);

        // Rising edge sampled at edge k must show up at k+3 and not before.
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("lat_k", 8'd10, 8'd6, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("lat_k1", 8'd10, 8'd6, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("lat_k2", 8'd10, 8'd6, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("lat_k3", 8'd10, 8'd6, 1'b1, 1'b0, 1'b0);

        // Edges shifted one clock early so synchronized fall/rise coincide with a tick.
        for (int r = 0; r < 2; r++) begin
            repeat (3) slot(1'b1, 1'b1);
            slot(1'b1, 1'b0);
            repeat (4) slot(1'b0, 1'b0);
            slot(1'b0, 1'b1);
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            chk($sformatf("coincide%0d", r), 8'd10, 8'd5, 1'b1, 1'b1, 1'b0);
            repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
